// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer for the signed ALU datapath: queues {sel,a,b},
// drives the ALU inputs for a fixed latency, then returns C/Z on a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [SEL_W-1:0]              cmd_sel,
    input  logic [DATA_W-1:0]             cmd_a,
    input  logic [DATA_W-1:0]             cmd_b,
    output logic [SEL_W-1:0]              alu_sel,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    input  logic [DATA_W-1:0]             alu_c,
    input  logic                          alu_z,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_c,
    output logic                          rsp_z,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned LAT_W = $clog2(LATENCY + 1);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    cmd_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    cmd_t              alu_q, alu_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_c_q, rsp_c_d;
    logic              rsp_z_q, rsp_z_d;

    logic push;
    logic pop;
    logic empty;
    cmd_t head;

    assign empty     = (count_q == '0);
    assign cmd_ready = (count_q != OCC_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // FIFO storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    // Issue / wait / respond sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_d       = alu_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_z_d     = rsp_z_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    alu_d   = head;
                    cnt_d   = LAT_W'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_c_d     = alu_c;
                    rsp_z_d     = alu_z;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        alu_d   = head;
                        cnt_d   = LAT_W'(LATENCY);
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_z_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_q       <= alu_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_z_q     <= rsp_z_d;
        end
    end

    assign alu_sel   = alu_q.sel;
    assign alu_a     = alu_q.a;
    assign alu_b     = alu_q.b;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_z     = rsp_z_q;
    assign busy      = (state_q != IDLE) || !empty;
    assign cmd_count = count_q;

endmodule
